data_demux: RTL and testbench
=============================

// Module: data_demux
// PURPOSE
//  Frame demultiplexer: pops framed words from one input FIFO and forwards payload to one of n
//  output FIFOs. Output side uses a shared tx bus plus per-FIFO clock enables, matching
//  data_matrix outputs. Sits downstream of a link receiver; its outputs feed data_matrix input FIFOs.
//  Frame format: word0 = header (dest index in bits [$clog2(n)-1:0]); word1 = payload length
//  L (0..2^o-1); then L payload words.
// PARAMETERS
//  n  4  number of output (tx) ports; must satisfy $clog2(n) < o-1
//  o  8  parallel data width (input and output)
// PORTS
//  clk      in   1   master clock
//  rst_n    in   1   asynchronous reset, active-low
//  rx       in   o   head word of input FIFO, valid while rx_rdy=1
//  rx_rdy   in   1   input FIFO not empty
//  rx_pop   out  1   one-clk pulse: remove head word from input FIFO
//  tx_full  in   n   per-output FIFO full flags
//  tx       out  o   payload word, shared by all output FIFOs
//  tx_cke   out  n   per-output FIFO write enables, valid with tx
//  drop     out  1   one-clk pulse when a header with invalid dest is consumed
//  busy     out  1   high from header pop until last word of frame popped
// BEHAVIOUR
//  - Reset (async, rst_n=0): rx_pop=0, tx=0, tx_cke=0, drop=0, busy=0, state=HDR, counters=0.
//  - All outputs registered. Pop rule: rx_pop asserted for exactly 1 clk; the cycle after a pop
//    is a mandatory bubble (no pop) so rx/rx_rdy can update. Max rate 1 word / 2 clk.
//  - HDR: when rx_rdy=1 and no bubble: pop, latch dest=rx[$clog2(n)-1:0], busy<=1, -> LEN.
//    dest>=n (possible when n not a power of 2): drop pulses with the pop; frame marked invalid.
//  - LEN: when rx_rdy=1: pop, latch cnt=rx. cnt==0 -> HDR, busy<=0 same edge as pop; else -> PAY.
//  - PAY: valid frame: pop only when rx_rdy=1 and tx_full[dest]=0; same edge tx<=rx,
//    tx_cke<=one-hot(dest); cnt decrements. Invalid frame: pop regardless of tx_full,
//    tx_cke stays 0 (word discarded). cnt reaching 0 -> HDR, busy<=0.
//  - tx_cke is 0 on every cycle without a payload pop; tx holds last payload word.
//  - tx_full sampled in the deciding cycle; output FIFO must tolerate the 1-word registered lag
//    (full must assert with >=1 free slot, or equivalently full flag is registered-safe).
//  - rx_rdy=0 in any state: wait, no pop, state held; no timeout.
//  - tx_full[dest]=1 in PAY: stall indefinitely; other outputs unaffected (no reordering).
//  - Length width = o bits; cnt never wraps (stops at 0).
//  - Reset mid-frame: state returns to HDR; remaining words in input FIFO are parsed as a new
//    frame (resynchronisation is the upstream's duty).
// CONFIGURATION
//  Macro DATA_DEMUX_BCAST_EN:
//  - defined: header bit o-1 = broadcast flag. Broadcast frame: payload pop only when
//    tx_full==0 (all outputs), tx_cke<=all ones; dest bits ignored, never drops.
//  - undefined: header bit o-1 ignored; only dest bits decoded.
// TESTING
//  1 Reset: rst_n=0 async mid-PAY -> all outputs 0 immediately; after release, FIFO holds
//    {02,01,AA} -> tx=AA, tx_cke=0100, busy ends after AA popped.
//  2 Stream {01,03,11,22,33} -> tx 11,22,33 each with tx_cke=0010; rx_pop never high 2 clk
//    in a row; 5 pops total.
//  3 Zero length {03,00} then {00,01,5A} -> no tx_cke for first frame, then 5A to tx_cke=0001.
//  4 Backpressure {02,02,C1,C2}, tx_full[2]=1 for 10 clk after C1 written -> C2 held,
//    no pop for 10 clk, then C2 to tx_cke=0100.
//  5 n=3: {03,02,E1,E2} -> drop=1 one clk at header pop; E1,E2 popped with tx_cke=000.
//  6 DATA_DEMUX_BCAST_EN: {80,01,77}, tx_full=0000 -> tx=77, tx_cke=1111; with
//    tx_full=0001 held -> stall; without macro same frame -> 77 to tx_cke=0001.

Source files
------------

// File: rtl/data_demux.sv
// Frame demultiplexer: pops {header, length, payload...} frames from one input FIFO and
// writes payload to the output FIFO selected by the header. Optional macro: DATA_DEMUX_BCAST_EN.
module data_demux #(
    parameter int n = 4,
    parameter int o = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [o-1:0] rx,
    input  logic         rx_rdy,
    output logic         rx_pop,
    input  logic [n-1:0] tx_full,
    output logic [o-1:0] tx,
    output logic [n-1:0] tx_cke,
    output logic         drop,
    output logic         busy
);

    localparam int DW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {HDR, LEN, PAY} state_t;

    state_t         state_reg, state_next;
    logic [DW-1:0]  dest_reg, dest_next;
    logic [o-1:0]   cnt_reg, cnt_next;
    logic           invalid_reg, invalid_next;
    logic           bcast_reg, bcast_next;
    logic           rx_pop_reg, rx_pop_next;
    logic [o-1:0]   tx_reg, tx_next;
    logic [n-1:0]   tx_cke_reg, tx_cke_next;
    logic           drop_reg, drop_next;
    logic           busy_reg, busy_next;

    logic           hdr_bcast;
    logic           hdr_invalid;
    logic           can_pop;
    logic           pay_ok;

`ifdef DATA_DEMUX_BCAST_EN
    assign hdr_bcast = rx[o-1];
`else
    assign hdr_bcast = 1'b0;
`endif

    // Out-of-range destinations only exist when n is not a power of two.
    generate
        if ((1 << DW) == n) begin : g_pow2
            assign hdr_invalid = 1'b0;
        end else begin : g_npow2
            assign hdr_invalid = (rx[DW-1:0] >= DW'(n));
        end
    endgenerate

    // A pop is still in flight while rx_pop_reg is high, so the head word is stale.
    assign can_pop = rx_rdy && !rx_pop_reg;

    always_comb begin
        pay_ok = 1'b0;
        if (bcast_reg)
            pay_ok = (tx_full == '0);
        else if (invalid_reg)
            pay_ok = 1'b1;
        else
            pay_ok = !tx_full[dest_reg];
    end

    always_comb begin
        state_next   = state_reg;
        dest_next    = dest_reg;
        cnt_next     = cnt_reg;
        invalid_next = invalid_reg;
        bcast_next   = bcast_reg;
        rx_pop_next  = 1'b0;
        tx_next      = tx_reg;
        tx_cke_next  = '0;
        drop_next    = 1'b0;
        busy_next    = busy_reg;

        case (state_reg)
            HDR: begin
                if (can_pop) begin
                    rx_pop_next  = 1'b1;
                    dest_next    = rx[DW-1:0];
                    bcast_next   = hdr_bcast;
                    invalid_next = hdr_invalid && !hdr_bcast;
                    drop_next    = hdr_invalid && !hdr_bcast;
                    busy_next    = 1'b1;
                    state_next   = LEN;
                end
            end
            LEN: begin
                if (can_pop) begin
                    rx_pop_next = 1'b1;
                    cnt_next    = rx;
                    if (rx == '0) begin
                        busy_next  = 1'b0;
                        state_next = HDR;
                    end else begin
                        state_next = PAY;
                    end
                end
            end
            PAY: begin
                if (can_pop && pay_ok) begin
                    rx_pop_next = 1'b1;
                    if (cnt_reg != '0)
                        cnt_next = cnt_reg - 1'b1;
                    if (!invalid_reg) begin
                        tx_next     = rx;
                        tx_cke_next = bcast_reg ? {n{1'b1}}
                                                : ({{(n-1){1'b0}}, 1'b1} << dest_reg);
                    end
                    if (cnt_reg <= o'(1)) begin
                        busy_next  = 1'b0;
                        state_next = HDR;
                    end
                end
            end
            default: state_next = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= HDR;
            dest_reg    <= '0;
            cnt_reg     <= '0;
            invalid_reg <= 1'b0;
            bcast_reg   <= 1'b0;
            rx_pop_reg  <= 1'b0;
            tx_reg      <= '0;
            tx_cke_reg  <= '0;
            drop_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dest_reg    <= dest_next;
            cnt_reg     <= cnt_next;
            invalid_reg <= invalid_next;
            bcast_reg   <= bcast_next;
            rx_pop_reg  <= rx_pop_next;
            tx_reg      <= tx_next;
            tx_cke_reg  <= tx_cke_next;
            drop_reg    <= drop_next;
            busy_reg    <= busy_next;
        end
    end

    assign rx_pop = rx_pop_reg;
    assign tx     = tx_reg;
    assign tx_cke = tx_cke_reg;
    assign drop   = drop_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_data_demux.sv
// Directed bench for data_demux: n=4 instance for the main frames, n=3 instance for drop.
// Queues model the input FIFOs; every output write is logged and compared to hand values.
module tb_data_demux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // n=4 instance
    logic [7:0] rx4 = 8'h00;
    logic       rx_rdy4 = 1'b0;
    logic       rx_pop4;
    logic [3:0] tx_full4 = 4'b0000;
    logic [7:0] tx4;
    logic [3:0] tx_cke4;
    logic       drop4;
    logic       busy4;

    // n=3 instance
    logic [7:0] rx3 = 8'h00;
    logic       rx_rdy3 = 1'b0;
    logic       rx_pop3;
    logic [2:0] tx_full3 = 3'b000;
    logic [7:0] tx3;
    logic [2:0] tx_cke3;
    logic       drop3;
    logic       busy3;

    logic [7:0] q4[$];
    logic [7:0] q3[$];
    logic [7:0] log_d4[$];
    logic [3:0] log_c4[$];
    logic [7:0] log_d3[$];
    logic [2:0] log_c3[$];
    int         pop_cnt4 = 0;
    int         dbl_cnt4 = 0;
    int         pop_cnt3 = 0;
    int         drop_cnt3 = 0;
    logic       prev_pop4 = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    data_demux #(.n(4), .o(8)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx4),
        .rx_rdy  (rx_rdy4),
        .rx_pop  (rx_pop4),
        .tx_full (tx_full4),
        .tx      (tx4),
        .tx_cke  (tx_cke4),
        .drop    (drop4),
        .busy    (busy4)
    );

    data_demux #(.n(3), .o(8)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx3),
        .rx_rdy  (rx_rdy3),
        .rx_pop  (rx_pop3),
        .tx_full (tx_full3),
        .tx      (tx3),
        .tx_cke  (tx_cke3),
        .drop    (drop3),
        .busy    (busy3)
    );

    // Input FIFO models and output loggers, all on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_pop4 && q4.size() > 0) begin
                void'(q4.pop_front());
                pop_cnt4 = pop_cnt4 + 1;
            end
            if (rx_pop4 && prev_pop4)
                dbl_cnt4 = dbl_cnt4 + 1;
            prev_pop4 = rx_pop4;
            if (tx_cke4 != 4'b0000) begin
                log_d4.push_back(tx4);
                log_c4.push_back(tx_cke4);
            end
            if (rx_pop3 && q3.size() > 0) begin
                void'(q3.pop_front());
                pop_cnt3 = pop_cnt3 + 1;
            end
            if (drop3)
                drop_cnt3 = drop_cnt3 + 1;
            if (tx_cke3 != 3'b000) begin
                log_d3.push_back(tx3);
                log_c3.push_back(tx_cke3);
            end
        end else begin
            prev_pop4 = 1'b0;
        end
        rx_rdy4 = (q4.size() > 0);
        rx4     = rx_rdy4 ? q4[0] : 8'h00;
        rx_rdy3 = (q3.size() > 0);
        rx3     = rx_rdy3 ? q3[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic wait_clks(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    task automatic clear_logs;
        log_d4.delete();
        log_c4.delete();
        log_d3.delete();
        log_c3.delete();
        pop_cnt4  = 0;
        dbl_cnt4  = 0;
        pop_cnt3  = 0;
        drop_cnt3 = 0;
    endtask

    initial begin
        wait_clks(3);
        check("rst_rx_pop", 32'(rx_pop4), 32'h0);
        check("rst_tx",     32'(tx4),     32'h0);
        check("rst_tx_cke", 32'(tx_cke4), 32'h0);
        check("rst_busy",   32'(busy4),   32'h0);

        // 1: async reset in the middle of a payload, then a clean frame
        rst_n = 1'b1;
        q4 = '{8'h01, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        wait_clks(9);
        check("t1_busy_pre", 32'(busy4), 32'h1);
        check("t1_wrote_some", 32'(log_d4.size() > 0), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_rst_rx_pop", 32'(rx_pop4), 32'h0);
        check("t1_rst_tx",     32'(tx4),     32'h0);
        check("t1_rst_tx_cke", 32'(tx_cke4), 32'h0);
        check("t1_rst_drop",   32'(drop4),   32'h0);
        check("t1_rst_busy",   32'(busy4),   32'h0);
        q4 = '{8'h02, 8'h01, 8'hAA};
        wait_clks(2);
        clear_logs();
        rst_n = 1'b1;
        wait_clks(16);
        check("t1_nwr",  32'(log_d4.size()), 32'd1);
        if (log_d4.size() > 0) begin
            check("t1_data", 32'(log_d4[0]), 32'hAA);
            check("t1_cke",  32'(log_c4[0]), 32'h4);
        end
        check("t1_busy_end", 32'(busy4), 32'h0);
        check("t1_pops", 32'(pop_cnt4), 32'd3);

        // 2: three-word stream to port 1
        clear_logs();
        q4 = '{8'h01, 8'h03, 8'h11, 8'h22, 8'h33};
        wait_clks(20);
        check("t2_nwr", 32'(log_d4.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_d4.size(); i++) begin
            check($sformatf("t2_data%0d", i), 32'(log_d4[i]), 32'(8'h11 * (i + 1)));
            check($sformatf("t2_cke%0d", i),  32'(log_c4[i]), 32'h2);
        end
        check("t2_pops", 32'(pop_cnt4), 32'd5);
        check("t2_back_to_back", 32'(dbl_cnt4), 32'd0);
        check("t2_busy_end", 32'(busy4), 32'h0);

        // 3: zero-length frame followed by a one-word frame
        clear_logs();
        q4 = '{8'h03, 8'h00, 8'h00, 8'h01, 8'h5A};
        wait_clks(20);
        check("t3_nwr", 32'(log_d4.size()), 32'd1);
        if (log_d4.size() > 0) begin
            check("t3_data", 32'(log_d4[0]), 32'h5A);
            check("t3_cke",  32'(log_c4[0]), 32'h1);
        end
        check("t3_pops", 32'(pop_cnt4), 32'd5);

        // 4: backpressure on port 2 after the first payload word
        clear_logs();
        q4 = '{8'h02, 8'h02, 8'hC1, 8'hC2};
        for (int k = 0; k < 40 && log_d4.size() == 0; k++) @(negedge clk);
        check("t4_c1_seen", 32'(log_d4.size() > 0), 32'h1);
        tx_full4 = 4'b0100;
        begin
            int pops_at_stall;
            pops_at_stall = pop_cnt4;
            wait_clks(10);
            check("t4_stall_pops", 32'(pop_cnt4), 32'(pops_at_stall));
        end
        check("t4_stall_nwr", 32'(log_d4.size()), 32'd1);
        check("t4_stall_busy", 32'(busy4), 32'h1);
        tx_full4 = 4'b0000;
        wait_clks(10);
        check("t4_nwr", 32'(log_d4.size()), 32'd2);
        if (log_d4.size() > 1) begin
            check("t4_data1", 32'(log_d4[0]), 32'hC1);
            check("t4_data2", 32'(log_d4[1]), 32'hC2);
            check("t4_cke2",  32'(log_c4[1]), 32'h4);
        end
        check("t4_busy_end", 32'(busy4), 32'h0);

        // 5: n=3, invalid destination 3 is dropped, then a valid frame to port 2
        clear_logs();
        q3 = '{8'h03, 8'h02, 8'hE1, 8'hE2};
        wait_clks(20);
        check("t5_drops", 32'(drop_cnt3), 32'd1);
        check("t5_nwr",   32'(log_d3.size()), 32'd0);
        check("t5_pops",  32'(pop_cnt3), 32'd4);
        check("t5_busy_end", 32'(busy3), 32'h0);
        q3 = '{8'h02, 8'h01, 8'hB7};
        wait_clks(16);
        check("t5_valid_nwr", 32'(log_d3.size()), 32'd1);
        if (log_d3.size() > 0) begin
            check("t5_valid_data", 32'(log_d3[0]), 32'hB7);
            check("t5_valid_cke",  32'(log_c3[0]), 32'h4);
        end
        check("t5_valid_drops", 32'(drop_cnt3), 32'd1);

        // 6: header with bit 7 set; port 0 full first, then everything free
        clear_logs();
        tx_full4 = 4'b0001;
        q4 = '{8'h80, 8'h01, 8'h77};
        wait_clks(20);
        check("t6_stall_nwr", 32'(log_d4.size()), 32'd0);
        check("t6_stall_busy", 32'(busy4), 32'h1);
        tx_full4 = 4'b0000;
        wait_clks(10);
        check("t6_nwr", 32'(log_d4.size()), 32'd1);
        if (log_d4.size() > 0) begin
            check("t6_data", 32'(log_d4[0]), 32'h77);
`ifdef DATA_DEMUX_BCAST_EN
            check("t6_cke", 32'(log_c4[0]), 32'hF);
`else
            check("t6_cke", 32'(log_c4[0]), 32'h1);
`endif
        end
        check("t6_drop", 32'(drop4), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
